// File: rtl/reg_file_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_file_scoreboard
//   2-read / 1-write register file with a per-register busy scoreboard and an
//   optional writeback bypass. It sits between decode (issue) and writeback
//   and reports pending operands, so decode can stall on RAW and WAW hazards.
//
// Parameters
//   DATA_W  register width in bits
//   ADDR_W  register address width (2**ADDR_W entries)
//   BYPASS  1: writeback data/clear is visible to same-cycle reads
//           0: writeback is visible from the next cycle on
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   rs_addr/rt_addr       read addresses
//   rs_data/rt_data       effective read data (combinational)
//   rs_busy/rt_busy       effective busy of the read addresses (combinational)
//   issue_en/issue_rd     issue request and destination to reserve
//   issue_stall           issue refused this cycle (combinational)
//   wb_en/wb_addr/wb_data writeback strobe, address and data
//   pending_cnt           number of busy registers (registered)
//   wb_err                sticky: writeback to a non-busy, nonzero register
// ---------------------------------------------------------------------------
module reg_file_scoreboard #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rs_busy,
    output logic              rt_busy,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_stall,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W:0]   pending_cnt,
    output logic              wb_err
);

    localparam int   NREG = 32'd1 << ADDR_W;
    localparam logic BYP  = (BYPASS != 0);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_d;
    logic              wb_err_q;
    logic              wb_err_d;

    logic              wb_live_s;
    logic              rs_hit_s;
    logic              rt_hit_s;
    logic              rd_hit_s;
    logic              rd_busy_s;
    logic              issue_acc_s;
    logic              wb_clr_s;

    // Writeback decode and bypass hits for each read/reserve address
    always_comb begin
        wb_live_s = wb_en && (wb_addr != {ADDR_W{1'b0}});
        rs_hit_s  = BYP && wb_live_s && (wb_addr == rs_addr);
        rt_hit_s  = BYP && wb_live_s && (wb_addr == rt_addr);
        rd_hit_s  = BYP && wb_live_s && (wb_addr == issue_rd);
    end

    // Effective read data: reg 0 is hard zero, a bypass hit forwards wb_data
    always_comb begin
        rs_data = {DATA_W{1'b0}};
        rt_data = {DATA_W{1'b0}};
        if (rs_addr == {ADDR_W{1'b0}}) begin
            rs_data = {DATA_W{1'b0}};
        end else if (rs_hit_s) begin
            rs_data = wb_data;
        end else begin
            rs_data = regs_q[rs_addr];
        end
        if (rt_addr == {ADDR_W{1'b0}}) begin
            rt_data = {DATA_W{1'b0}};
        end else if (rt_hit_s) begin
            rt_data = wb_data;
        end else begin
            rt_data = regs_q[rt_addr];
        end
    end

    // Effective busy flags and the issue decision
    always_comb begin
        // busy_q[0] is never set, so reg 0 reads as not busy without a special case
        rs_busy     = busy_q[rs_addr]  && !rs_hit_s;
        rt_busy     = busy_q[rt_addr]  && !rt_hit_s;
        rd_busy_s   = busy_q[issue_rd] && !rd_hit_s;
        issue_stall = issue_en && (rs_busy || rt_busy || rd_busy_s);
        issue_acc_s = issue_en && !issue_stall && (issue_rd != {ADDR_W{1'b0}});
        wb_clr_s    = wb_live_s && busy_q[wb_addr];
    end

    // Next-state: writeback first, then issue so a same-cycle issue wins on busy
    always_comb begin
        regs_d   = regs_q;
        busy_d   = busy_q;
        wb_err_d = wb_err_q;
        if (wb_live_s) begin
            regs_d[wb_addr] = wb_data;
            busy_d[wb_addr] = 1'b0;
            if (!busy_q[wb_addr]) begin
                wb_err_d = 1'b1;
            end else begin
                wb_err_d = wb_err_q;
            end
        end else begin
            busy_d = busy_q;
        end
        if (issue_acc_s) begin
            busy_d[issue_rd] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        // Issue and clear together leave the count unchanged, matching popcount(busy)
        cnt_d = cnt_q + {{ADDR_W{1'b0}}, issue_acc_s} - {{ADDR_W{1'b0}}, wb_clr_s};
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            busy_q   <= {NREG{1'b0}};
            cnt_q    <= {(ADDR_W+1){1'b0}};
            wb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            wb_err_q <= wb_err_d;
        end
    end

    assign pending_cnt = cnt_q;
    assign wb_err      = wb_err_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Bench: one BYPASS=0 and one BYPASS=1 instance share stimulus; both are
// compared every cycle against an array/popcount reference model.
module tb_reg_file_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs_addr, rt_addr, issue_rd, wb_addr;
    logic       issue_en, wb_en;
    logic [7:0] wb_data;

    logic [7:0] rs_data_b [2];
    logic [7:0] rt_data_b [2];
    logic       rs_busy_b [2];
    logic       rt_busy_b [2];
    logic       stall_b   [2];
    logic [5:0] cnt_b     [2];
    logic       err_b     [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_file_scoreboard #(.DATA_W(8), .ADDR_W(5), .BYPASS(0)) dut0 (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data_b[0]), .rt_data(rt_data_b[0]),
        .rs_busy(rs_busy_b[0]), .rt_busy(rt_busy_b[0]),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_stall(stall_b[0]),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .pending_cnt(cnt_b[0]), .wb_err(err_b[0])
    );

    reg_file_scoreboard #(.DATA_W(8), .ADDR_W(5), .BYPASS(1)) dut1 (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data_b[1]), .rt_data(rt_data_b[1]),
        .rs_busy(rs_busy_b[1]), .rt_busy(rt_busy_b[1]),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_stall(stall_b[1]),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .pending_cnt(cnt_b[1]), .wb_err(err_b[1])
    );

    // Reference model: k=0 is the BYPASS=0 instance, k=1 the BYPASS=1 instance
    logic [7:0] m_reg  [2][32];
    bit         m_busy [2][32];
    bit         m_err  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_hit(int k, int a);
        return (k == 1) && wb_en && (a != 0) && (int'(wb_addr) == a);
    endfunction

    function automatic logic [7:0] m_data(int k, int a);
        if (a == 0) return 8'h00;
        if (m_hit(k, a)) return wb_data;
        return m_reg[k][a];
    endfunction

    function automatic bit m_eb(int k, int a);
        return (a != 0) && m_busy[k][a] && !m_hit(k, a);
    endfunction

    function automatic bit m_stall(int k);
        return issue_en && (m_eb(k, int'(rs_addr)) || m_eb(k, int'(rt_addr)) || m_eb(k, int'(issue_rd)));
    endfunction

    function automatic int m_count(int k);
        int c = 0;
        for (int a = 0; a < 32; a++) c += int'(m_busy[k][a]);
        return c;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_err[k] = 1'b0;
            for (int a = 0; a < 32; a++) begin
                m_reg[k][a]  = 8'h00;
                m_busy[k][a] = 1'b0;
            end
        end
    endtask

    task automatic m_step();
        for (int k = 0; k < 2; k++) begin
            bit acc;
            acc = issue_en && !m_stall(k) && (issue_rd != 5'd0);
            if (wb_en && wb_addr != 5'd0) begin
                if (!m_busy[k][wb_addr]) m_err[k] = 1'b1;
                m_reg[k][wb_addr]  = wb_data;
                m_busy[k][wb_addr] = 1'b0;
            end
            if (acc) m_busy[k][issue_rd] = 1'b1;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rs_data[b%0d]", k), 32'(rs_data_b[k]), 32'(m_data(k, int'(rs_addr))));
            chk($sformatf("rt_data[b%0d]", k), 32'(rt_data_b[k]), 32'(m_data(k, int'(rt_addr))));
            chk($sformatf("rs_busy[b%0d]", k), 32'(rs_busy_b[k]), 32'(m_eb(k, int'(rs_addr))));
            chk($sformatf("rt_busy[b%0d]", k), 32'(rt_busy_b[k]), 32'(m_eb(k, int'(rt_addr))));
            chk($sformatf("stall[b%0d]", k),   32'(stall_b[k]),   32'(m_stall(k)));
            chk($sformatf("pending[b%0d]", k), 32'(cnt_b[k]),     32'(m_count(k)));
            chk($sformatf("wb_err[b%0d]", k),  32'(err_b[k]),     32'(m_err[k]));
        end
    endtask

    task automatic idle();
        rs_addr = 5'd0; rt_addr = 5'd0; issue_en = 1'b0; issue_rd = 5'd0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 8'h00;
    endtask

    // Model check at negedge, then one rising edge; returns at posedge+1
    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        m_reset();
        check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_pending[b%0d]", k), 32'(cnt_b[k]), 32'd0);
            chk($sformatf("rst_err[b%0d]", k),     32'(err_b[k]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        m_reset();
        do_reset();

        // Reset clears written data
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 8'h5A;
        cycle();
        idle(); rs_addr = 5'd3; #1;
        chk("r3_written", 32'(rs_data_b[1]), 32'h5A);
        do_reset();
        rs_addr = 5'd3; #1;
        chk("r3_after_rst[b0]", 32'(rs_data_b[0]), 32'h00);
        chk("r3_after_rst[b1]", 32'(rs_data_b[1]), 32'h00);

        // Register 0: writes and issues ignored, never stalled
        idle(); wb_en = 1'b1; wb_addr = 5'd0; wb_data = 8'hFF; issue_en = 1'b1; issue_rd = 5'd0; #1;
        chk("r0_stall[b0]", 32'(stall_b[0]), 32'd0);
        chk("r0_stall[b1]", 32'(stall_b[1]), 32'd0);
        cycle();
        idle(); #1;
        chk("r0_data[b1]",    32'(rs_data_b[1]), 32'h00);
        chk("r0_pending[b0]", 32'(cnt_b[0]), 32'd0);
        chk("r0_pending[b1]", 32'(cnt_b[1]), 32'd0);

        // RAW hazard and bypass behaviour
        issue_en = 1'b1; issue_rd = 5'd4;
        cycle();
        idle(); rs_addr = 5'd4; issue_en = 1'b1; #1;
        chk("raw_stall[b0]", 32'(stall_b[0]), 32'd1);
        chk("raw_stall[b1]", 32'(stall_b[1]), 32'd1);
        cycle();
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 8'h33; #1;
        chk("byp_data[b1]",  32'(rs_data_b[1]), 32'h33);
        chk("byp_stall[b1]", 32'(stall_b[1]), 32'd0);
        chk("nobyp_stall[b0]", 32'(stall_b[0]), 32'd1);
        cycle();
        wb_en = 1'b0; #1;
        chk("nobyp_next_stall[b0]", 32'(stall_b[0]), 32'd0);
        chk("nobyp_next_data[b0]",  32'(rs_data_b[0]), 32'h33);
        cycle();

        // WAW with same-cycle writeback: issue wins (BYPASS=1)
        idle(); issue_en = 1'b1; issue_rd = 5'd7;
        cycle();
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 8'h11; #1;
        chk("waw_stall[b1]", 32'(stall_b[1]), 32'd0);
        cycle();
        idle(); rs_addr = 5'd7; #1;
        chk("waw_data[b1]",    32'(rs_data_b[1]), 32'h11);
        chk("waw_busy[b1]",    32'(rs_busy_b[1]), 32'd1);
        chk("waw_pending[b1]", 32'(cnt_b[1]), 32'd1);
        cycle();
        do_reset();
        rs_addr = 5'd7; #1;
        chk("midrst_busy[b1]", 32'(rs_busy_b[1]), 32'd0);

        // Fill every register, then drain
        for (int i = 1; i < 32; i++) begin
            idle(); issue_en = 1'b1; issue_rd = 5'(i);
            cycle();
        end
        idle(); #1;
        chk("fill_pending[b0]", 32'(cnt_b[0]), 32'd31);
        chk("fill_pending[b1]", 32'(cnt_b[1]), 32'd31);
        for (int i = 1; i < 32; i++) begin
            idle(); wb_en = 1'b1; wb_addr = 5'(i); wb_data = 8'(i * 3);
            cycle();
        end
        idle(); #1;
        chk("drain_pending[b0]", 32'(cnt_b[0]), 32'd0);
        chk("drain_pending[b1]", 32'(cnt_b[1]), 32'd0);
        chk("drain_err[b0]",     32'(err_b[0]), 32'd0);
        chk("drain_err[b1]",     32'(err_b[1]), 32'd0);

        // Spurious writeback sets the sticky error
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 8'h42;
        cycle();
        idle(); rs_addr = 5'd9; #1;
        chk("spur_data[b0]", 32'(rs_data_b[0]), 32'h42);
        chk("spur_err[b0]",  32'(err_b[0]), 32'd1);
        chk("spur_err[b1]",  32'(err_b[1]), 32'd1);
        repeat (5) cycle();
        chk("spur_hold[b1]", 32'(err_b[1]), 32'd1);
        do_reset();

        // Randomized traffic, writebacks mostly aimed at busy registers
        for (int n = 0; n < 400; n++) begin
            int a;
            rs_addr  = 5'($urandom_range(31));
            rt_addr  = ($urandom_range(1) == 0) ? 5'd0 : 5'($urandom_range(31));
            issue_en = 1'($urandom_range(1));
            issue_rd = 5'($urandom_range(31));
            wb_en    = ($urandom_range(2) != 0);
            wb_data  = 8'($urandom);
            a = $urandom_range(31);
            if ($urandom_range(7) != 0) begin
                for (int j = 0; j < 32; j++) begin
                    if (m_busy[1][(a + j) % 32]) begin
                        a = (a + j) % 32;
                        break;
                    end
                end
            end
            wb_addr = 5'(a);
            cycle();
        end
        idle();
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
